// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: NOP encoding, reset address, FSM state encodings.
package fetch_stage_pkg;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] RESET_ADDR = 32'h0000_1000;

  typedef enum logic [1:0] {
    FETCH_ISSUE = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_BUF   = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch, one outstanding imem request; response to decode output in 1 cycle.
// Stall freezes the output register; a response arriving under stall parks in a one-entry buffer.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_ADDR,
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  fetch_state_t state, state_next;
  logic [31:0]  fetch_pc, fetch_pc_next;
  logic [31:0]  req_pc, req_pc_next;
  logic [31:0]  buf_instr, buf_instr_next;
  logic [31:0]  buf_pc, buf_pc_next;
  logic         drop, drop_next;
  logic         instr_valid_next;
  logic [31:0]  instr_next, pc_next;

  logic         accept;
  logic         flush;
  logic [31:0]  target;

  assign imem_req_valid = (state == FETCH_ISSUE) && !rst;
  assign imem_req_addr  = fetch_pc;

  assign accept = (state == FETCH_ISSUE) && imem_req_ready;
  assign flush  = exc_valid || redirect_valid;
  assign target = word_align(exc_valid ? exc_pc : redirect_pc);

  always_comb begin
    state_next       = state;
    fetch_pc_next    = fetch_pc;
    req_pc_next      = req_pc;
    buf_instr_next   = buf_instr;
    buf_pc_next      = buf_pc;
    drop_next        = drop;
    instr_valid_next = instr_valid;
    instr_next       = instr;
    pc_next          = pc;

    if (instr_valid && !stall) begin
      instr_valid_next = 1'b0;
      instr_next       = NOP_INSTR;
    end

    case (state)
      FETCH_ISSUE: begin
        if (accept) begin
          req_pc_next   = fetch_pc;
          fetch_pc_next = fetch_pc + 32'd4;
          state_next    = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem_resp_valid) begin
          if (drop) begin
            drop_next  = 1'b0;
            state_next = FETCH_ISSUE;
          end else if (!instr_valid || !stall) begin
            instr_valid_next = 1'b1;
            instr_next       = imem_resp_data;
            pc_next          = req_pc;
            state_next       = FETCH_ISSUE;
          end else begin
            buf_instr_next = imem_resp_data;
            buf_pc_next    = req_pc;
            state_next     = FETCH_BUF;
          end
        end
      end
      FETCH_BUF: begin
        if (!stall) begin
          instr_valid_next = 1'b1;
          instr_next       = buf_instr;
          pc_next          = buf_pc;
          state_next       = FETCH_ISSUE;
        end
      end
      default: state_next = FETCH_ISSUE;
    endcase

    // Redirects win over stall; a word still in flight must be swallowed when it returns.
    if (flush) begin
      fetch_pc_next    = target;
      instr_valid_next = 1'b0;
      instr_next       = NOP_INSTR;
      case (state)
        FETCH_ISSUE: begin
          if (accept) begin
            drop_next  = 1'b1;
            state_next = FETCH_WAIT;
          end else begin
            state_next = FETCH_ISSUE;
          end
        end
        FETCH_WAIT: begin
          if (imem_resp_valid) begin
            drop_next  = 1'b0;
            state_next = FETCH_ISSUE;
          end else begin
            drop_next  = 1'b1;
            state_next = FETCH_WAIT;
          end
        end
        default: state_next = FETCH_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH_ISSUE;
      fetch_pc    <= RESET_PC;
      req_pc      <= 32'd0;
      buf_instr   <= NOP_INSTR;
      buf_pc      <= 32'd0;
      drop        <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      pc          <= 32'd0;
    end else begin
      state       <= state_next;
      fetch_pc    <= fetch_pc_next;
      req_pc      <= req_pc_next;
      buf_instr   <= buf_instr_next;
      buf_pc      <= buf_pc_next;
      drop        <= drop_next;
      instr_valid <= instr_valid_next;
      instr       <= instr_next;
      pc          <= pc_next;
    end
  end

endmodule
